// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction-fetch / load-store memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around mem_arbiter.
// slave = the arbiter's view; master = the core/memory environment's view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [1:0]        dm_size;
    logic              dm_gnt;
    logic              dm_rvalid;

    logic [DATA_W-1:0] rdata;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [1:0]        m_size;
    logic              m_gnt;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;

    logic              stall;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_size,
               m_gnt, m_rvalid, m_rdata,
        output if_gnt, if_rvalid, dm_gnt, dm_rvalid, rdata,
               m_req, m_we, m_addr, m_wdata, m_size, stall
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_size,
               m_gnt, m_rvalid, m_rdata,
        input  if_gnt, if_rvalid, dm_gnt, dm_rvalid, rdata,
               m_req, m_we, m_addr, m_wdata, m_size, stall
    );
endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational two-way picker between fetch and data requests.
// MEM_ARB_RR_EN selects round-robin tie breaking; otherwise data always wins a tie.
module arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic   take_i,
    input  owner_t last_i,
    output owner_t last_o,
`endif
    input  logic   if_req_i,
    input  logic   dm_req_i,
    output owner_t pick_o,
    output logic   valid_o
);

    assign valid_o = if_req_i | dm_req_i;

    always_comb begin
        pick_o = OWN_IF;
        if (if_req_i && dm_req_i) begin
`ifdef MEM_ARB_RR_EN
            pick_o = (last_i == OWN_IF) ? OWN_DM : OWN_IF;
`else
            pick_o = OWN_DM;
`endif
        end else if (dm_req_i) begin
            pick_o = OWN_DM;
        end
    end

`ifdef MEM_ARB_RR_EN
    assign last_o = take_i ? pick_o : last_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store accesses onto one memory port, one outstanding.
// Build option: MEM_ARB_RR_EN enables round-robin tie breaking.
//
// state | meaning
// IDLE  | no transaction; capture the winning request and pulse its gnt
// REQ   | m_req held with stable fields until m_gnt
// WAIT  | accepted; route m_rvalid to the owner, then back to IDLE
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    state_t            state_q;
    owner_t            owner_q;
    logic              m_req_q;
    logic              m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic [1:0]        m_size_q;

    owner_t            pick;
    logic              any_req;
    logic              take;
    logic              resp;

`ifdef MEM_ARB_RR_EN
    owner_t            last_q;
    owner_t            last_d;

    arb_pick u_pick (
        .take_i   (take),
        .last_i   (last_q),
        .last_o   (last_d),
        .if_req_i (bus.if_req),
        .dm_req_i (bus.dm_req),
        .pick_o   (pick),
        .valid_o  (any_req)
    );
`else
    arb_pick u_pick (
        .if_req_i (bus.if_req),
        .dm_req_i (bus.dm_req),
        .pick_o   (pick),
        .valid_o  (any_req)
    );
`endif

    // Grant and response are Mealy pulses; reset masks them so nothing leaks out.
    assign take = rst && (state_q == IDLE) && any_req;
    assign resp = rst && (state_q == WAIT) && bus.m_rvalid;

    assign bus.if_gnt    = take && (pick == OWN_IF);
    assign bus.dm_gnt    = take && (pick == OWN_DM);
    assign bus.if_rvalid = resp && (owner_q == OWN_IF);
    assign bus.dm_rvalid = resp && (owner_q == OWN_DM);
    assign bus.rdata     = bus.m_rdata;

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_size  = m_size_q;

    assign bus.stall = bus.if_req | bus.dm_req | (state_q == REQ) |
                       ((state_q == WAIT) & ~bus.m_rvalid);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IF;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_size_q  <= SZ_B;
`ifdef MEM_ARB_RR_EN
            last_q    <= OWN_IF;
`endif
        end else begin
`ifdef MEM_ARB_RR_EN
            last_q <= last_d;
`endif
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q <= REQ;
                        m_req_q <= 1'b1;
                        owner_q <= pick;
                        if (pick == OWN_DM) begin
                            m_we_q    <= bus.dm_we;
                            m_addr_q  <= bus.dm_addr;
                            m_wdata_q <= bus.dm_wdata;
                            m_size_q  <= bus.dm_size;
                        end else begin
                            m_we_q    <= 1'b0;
                            m_addr_q  <= bus.if_addr;
                            m_wdata_q <= '0;
                            m_size_q  <= SZ_D;
                        end
                    end
                end
                REQ: begin
                    if (bus.m_gnt) begin
                        state_q <= WAIT;
                        m_req_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.m_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    m_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        bus.dm_size  = 2'b00;
        bus.m_gnt    = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = '0;
    endtask

    task automatic test_reset();
        quiet();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_vec++; if (bus.m_req !== 1'b0) begin n_err++; $display("FAIL rst_m_req got %b exp 0", bus.m_req); end
        n_vec++; if (bus.m_we !== 1'b0) begin n_err++; $display("FAIL rst_m_we got %b exp 0", bus.m_we); end
        n_vec++; if (bus.m_addr !== 64'd0) begin n_err++; $display("FAIL rst_m_addr got %h exp 0", bus.m_addr); end
        n_vec++; if (bus.m_wdata !== 64'd0) begin n_err++; $display("FAIL rst_m_wdata got %h exp 0", bus.m_wdata); end
        n_vec++; if (bus.m_size !== 2'b00) begin n_err++; $display("FAIL rst_m_size got %b exp 0", bus.m_size); end
        n_vec++; if ({bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid} !== 4'b0000) begin
            n_err++; $display("FAIL rst_handshake got %b exp 0000", {bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid});
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b exp 0", bus.stall); end
        n_vec++; if (bus.m_req !== 1'b0) begin n_err++; $display("FAIL idle_m_req got %b exp 0", bus.m_req); end
        tick();
    endtask

    task automatic test_lone_fetch();
        bus.if_req  = 1'b1;
        bus.if_addr = 64'h1000;
        @(negedge clk);
        n_vec++; if ({bus.if_gnt, bus.dm_gnt} !== 2'b10) begin n_err++; $display("FAIL fetch_gnt got %b exp 10", {bus.if_gnt, bus.dm_gnt}); end
        n_vec++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL fetch_stall_n got %b exp 1", bus.stall); end
        tick();
        bus.if_req = 1'b0;
        bus.m_gnt  = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.m_req !== 1'b1) begin n_err++; $display("FAIL fetch_m_req got %b exp 1", bus.m_req); end
        n_vec++; if (bus.m_addr !== 64'h1000) begin n_err++; $display("FAIL fetch_m_addr got %h exp 1000", bus.m_addr); end
        n_vec++; if ({bus.m_we, bus.m_size} !== 3'b011) begin n_err++; $display("FAIL fetch_we_size got %b exp 011", {bus.m_we, bus.m_size}); end
        tick();
        bus.m_gnt    = 1'b0;
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 64'h13;
        @(negedge clk);
        n_vec++; if ({bus.if_rvalid, bus.dm_rvalid} !== 2'b10) begin n_err++; $display("FAIL fetch_rvalid got %b exp 10", {bus.if_rvalid, bus.dm_rvalid}); end
        n_vec++; if (bus.rdata !== 64'h13) begin n_err++; $display("FAIL fetch_rdata got %h exp 13", bus.rdata); end
        n_vec++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL fetch_stall_n2 got %b exp 0", bus.stall); end
        n_vec++; if (bus.m_req !== 1'b0) begin n_err++; $display("FAIL fetch_m_req_wait got %b exp 0", bus.m_req); end
        tick();
        bus.m_rvalid = 1'b0;
        @(negedge clk);
        n_vec++; if ({bus.if_rvalid, bus.m_req} !== 2'b00) begin n_err++; $display("FAIL fetch_done got %b exp 00", {bus.if_rvalid, bus.m_req}); end
        tick();
    endtask

    task automatic test_tie();
        bus.if_req   = 1'b1;
        bus.if_addr  = 64'h1004;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 64'h2000;
        bus.dm_wdata = 64'hDEAD;
        bus.dm_size  = 2'b10;
        @(negedge clk);
        n_vec++; if ({bus.if_gnt, bus.dm_gnt} !== 2'b01) begin n_err++; $display("FAIL tie_first_gnt got %b exp 01", {bus.if_gnt, bus.dm_gnt}); end
        tick();
        bus.dm_req = 1'b0;
        bus.m_gnt  = 1'b1;
        @(negedge clk);
        n_vec++; if ({bus.m_req, bus.m_we, bus.m_size} !== 4'b1110) begin n_err++; $display("FAIL tie_store_fields got %b exp 1110", {bus.m_req, bus.m_we, bus.m_size}); end
        n_vec++; if ({bus.m_addr, bus.m_wdata} !== {64'h2000, 64'hDEAD}) begin n_err++; $display("FAIL tie_store_data got %h/%h exp 2000/dead", bus.m_addr, bus.m_wdata); end
        n_vec++; if (bus.if_gnt !== 1'b0) begin n_err++; $display("FAIL tie_if_wait1 got %b exp 0", bus.if_gnt); end
        tick();
        bus.m_gnt    = 1'b0;
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 64'h55;
        @(negedge clk);
        n_vec++; if ({bus.if_rvalid, bus.dm_rvalid, bus.if_gnt} !== 3'b010) begin n_err++; $display("FAIL tie_store_ack got %b exp 010", {bus.if_rvalid, bus.dm_rvalid, bus.if_gnt}); end
        tick();
        bus.m_rvalid = 1'b0;
        @(negedge clk);
        n_vec++; if ({bus.if_gnt, bus.dm_gnt} !== 2'b10) begin n_err++; $display("FAIL tie_second_gnt got %b exp 10", {bus.if_gnt, bus.dm_gnt}); end
        tick();
        bus.if_req = 1'b0;
        bus.m_gnt  = 1'b1;
        @(negedge clk);
        n_vec++; if ({bus.m_we, bus.m_size, bus.m_addr} !== {1'b0, 2'b11, 64'h1004}) begin n_err++; $display("FAIL tie_fetch_fields got we=%b size=%b addr=%h exp 0/11/1004", bus.m_we, bus.m_size, bus.m_addr); end
        tick();
        bus.m_gnt    = 1'b0;
        bus.m_rvalid = 1'b1;
        @(negedge clk);
        n_vec++; if ({bus.if_rvalid, bus.dm_rvalid} !== 2'b10) begin n_err++; $display("FAIL tie_fetch_resp got %b exp 10", {bus.if_rvalid, bus.dm_rvalid}); end
        tick();
        quiet();
        tick();
    endtask

    // The previous grant was a fetch, so the round-robin history starts at fetch.
    task automatic test_back_to_back_ties();
        logic last_dm;
        logic exp_dm;
        last_dm      = 1'b0;
        bus.if_req   = 1'b1;
        bus.if_addr  = 64'h5000;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = 64'h6000;
        bus.dm_size  = 2'b10;
        for (int k = 0; k < 3; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_dm = ~last_dm;
`else
            exp_dm = 1'b1;
`endif
            @(negedge clk);
            n_vec++; if ({bus.dm_gnt, bus.if_gnt} !== {exp_dm, ~exp_dm}) begin
                n_err++; $display("FAIL tie_series_%0d got dm/if=%b%b exp %b%b", k, bus.dm_gnt, bus.if_gnt, exp_dm, ~exp_dm);
            end
            last_dm = exp_dm;
            tick();
            if (exp_dm) bus.dm_req = 1'b0; else bus.if_req = 1'b0;
            bus.m_gnt = 1'b1;
            tick();
            bus.m_gnt    = 1'b0;
            bus.m_rvalid = 1'b1;
            tick();
            bus.m_rvalid = 1'b0;
            if (exp_dm) bus.dm_req = 1'b1; else bus.if_req = 1'b1;
        end
        quiet();
        tick();
    endtask

    task automatic test_slow_mem();
        bus.m_rvalid = 1'b1;
        @(negedge clk);
        n_vec++; if ({bus.if_rvalid, bus.dm_rvalid, bus.stall} !== 3'b000) begin n_err++; $display("FAIL slow_spur_idle0 got %b exp 000", {bus.if_rvalid, bus.dm_rvalid, bus.stall}); end
        tick();
        bus.m_rvalid = 1'b0;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = 64'h3000;
        bus.dm_size  = 2'b01;
        @(negedge clk);
        n_vec++; if (bus.dm_gnt !== 1'b1) begin n_err++; $display("FAIL slow_gnt got %b exp 1", bus.dm_gnt); end
        tick();
        bus.dm_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.m_gnt    = (i == 4);
            bus.m_rvalid = (i == 1);
            @(negedge clk);
            n_vec++; if ({bus.m_req, bus.m_we, bus.m_size, bus.m_addr} !== {1'b1, 1'b0, 2'b01, 64'h3000}) begin
                n_err++; $display("FAIL slow_req_%0d got req=%b we=%b size=%b addr=%h exp 1/0/01/3000", i, bus.m_req, bus.m_we, bus.m_size, bus.m_addr);
            end
            n_vec++; if ({bus.if_rvalid, bus.dm_rvalid, bus.stall} !== 3'b001) begin
                n_err++; $display("FAIL slow_req_rv_%0d got %b exp 001", i, {bus.if_rvalid, bus.dm_rvalid, bus.stall});
            end
            tick();
        end
        bus.m_gnt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.m_rvalid = (i == 5);
            bus.m_rdata  = 64'hABCD_0000 + 64'(i);
            @(negedge clk);
            n_vec++; if (bus.m_req !== 1'b0) begin n_err++; $display("FAIL slow_wait_req_%0d got %b exp 0", i, bus.m_req); end
            n_vec++; if ({bus.if_rvalid, bus.dm_rvalid, bus.stall} !== ((i == 5) ? 3'b010 : 3'b001)) begin
                n_err++; $display("FAIL slow_wait_%0d got %b exp %b", i, {bus.if_rvalid, bus.dm_rvalid, bus.stall}, (i == 5) ? 3'b010 : 3'b001);
            end
            if (i == 5) begin
                n_vec++; if (bus.rdata !== 64'hABCD_0005) begin n_err++; $display("FAIL slow_rdata got %h exp abcd0005", bus.rdata); end
            end
            tick();
        end
        bus.m_rvalid = 1'b1;
        @(negedge clk);
        n_vec++; if ({bus.if_rvalid, bus.dm_rvalid, bus.stall} !== 3'b000) begin n_err++; $display("FAIL slow_spur_idle1 got %b exp 000", {bus.if_rvalid, bus.dm_rvalid, bus.stall}); end
        tick();
        quiet();
    endtask

    task automatic test_reset_mid_wait();
        bus.if_req  = 1'b1;
        bus.if_addr = 64'h4000;
        @(negedge clk);
        n_vec++; if (bus.if_gnt !== 1'b1) begin n_err++; $display("FAIL rmw_gnt got %b exp 1", bus.if_gnt); end
        tick();
        bus.if_req = 1'b0;
        bus.m_gnt  = 1'b1;
        tick();
        bus.m_gnt = 1'b0;
        rst       = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if ({bus.m_req, bus.stall} !== 2'b00) begin n_err++; $display("FAIL rmw_idle got req/stall=%b exp 00", {bus.m_req, bus.stall}); end
        tick();
        bus.m_rvalid = 1'b1;
        @(negedge clk);
        n_vec++; if ({bus.if_rvalid, bus.dm_rvalid} !== 2'b00) begin n_err++; $display("FAIL rmw_late_rvalid got %b exp 00", {bus.if_rvalid, bus.dm_rvalid}); end
        tick();
        quiet();
    endtask

    // Transaction-level reference: one outstanding access; a tie goes to data
    // (or alternates under round-robin); the response belongs to the last grantee.
    task automatic test_random();
        logic        busy, acc, own, last_dm, exp_take, exp_dm, resp, mrv, mgnt;
        logic        t_we;
        logic [63:0] t_addr, t_wdata, mrd;
        logic [1:0]  t_size;
        int          cnt;
        int          n_if, n_dm;
        busy = 1'b0; acc = 1'b0; own = 1'b0; last_dm = 1'b0; cnt = 0;
        t_we = 1'b0; t_addr = '0; t_wdata = '0; t_size = 2'b00;
        n_if = 0; n_dm = 0;
        quiet();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (!bus.if_req && $urandom_range(0, 2) == 0) begin
                bus.if_req  = 1'b1;
                bus.if_addr = {$urandom, $urandom} & ~64'h3;
            end
            if (!bus.dm_req && $urandom_range(0, 2) == 0) begin
                bus.dm_req   = 1'b1;
                bus.dm_we    = 1'($urandom_range(0, 1));
                bus.dm_addr  = {$urandom, $urandom};
                bus.dm_wdata = {$urandom, $urandom};
                bus.dm_size  = 2'($urandom_range(0, 3));
            end
            mrd = {$urandom, $urandom};
            if (acc) begin
                mrv = (cnt == 0);
                if (cnt > 0) cnt--;
            end else begin
                mrv = ($urandom_range(0, 7) == 0);
            end
            mgnt = (busy && !acc) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            bus.m_rdata  = mrd;
            bus.m_rvalid = mrv;
            bus.m_gnt    = mgnt;

            @(negedge clk);
            exp_take = !busy && (bus.if_req || bus.dm_req);
`ifdef MEM_ARB_RR_EN
            exp_dm = bus.dm_req && (!bus.if_req || !last_dm);
`else
            exp_dm = bus.dm_req;
`endif
            resp = acc && mrv;
            n_vec++; if ({bus.if_gnt, bus.dm_gnt} !== {exp_take && !exp_dm, exp_take && exp_dm}) begin
                n_err++; $display("FAIL rnd_gnt c=%0d got %b%b exp %b%b", c, bus.if_gnt, bus.dm_gnt, exp_take && !exp_dm, exp_take && exp_dm);
            end
            n_vec++; if (bus.m_req !== (busy && !acc)) begin
                n_err++; $display("FAIL rnd_m_req c=%0d got %b exp %b", c, bus.m_req, busy && !acc);
            end
            if (busy && !acc) begin
                n_vec++; if ({bus.m_we, bus.m_size, bus.m_addr} !== {t_we, t_size, t_addr}) begin
                    n_err++; $display("FAIL rnd_fields c=%0d got we=%b size=%b addr=%h exp %b/%b/%h", c, bus.m_we, bus.m_size, bus.m_addr, t_we, t_size, t_addr);
                end
                if (t_we) begin
                    n_vec++; if (bus.m_wdata !== t_wdata) begin n_err++; $display("FAIL rnd_wdata c=%0d got %h exp %h", c, bus.m_wdata, t_wdata); end
                end
            end
            n_vec++; if ({bus.if_rvalid, bus.dm_rvalid} !== {resp && !own, resp && own}) begin
                n_err++; $display("FAIL rnd_rvalid c=%0d got %b%b exp %b%b", c, bus.if_rvalid, bus.dm_rvalid, resp && !own, resp && own);
            end
            if (resp) begin
                n_vec++; if (bus.rdata !== mrd) begin n_err++; $display("FAIL rnd_rdata c=%0d got %h exp %h", c, bus.rdata, mrd); end
            end
            n_vec++; if (bus.stall !== (bus.if_req || bus.dm_req || (busy && !resp))) begin
                n_err++; $display("FAIL rnd_stall c=%0d got %b exp %b", c, bus.stall, bus.if_req || bus.dm_req || (busy && !resp));
            end

            @(posedge clk);
            if (busy && !acc && mgnt) begin
                acc = 1'b1;
                cnt = $urandom_range(0, 3);
            end
            if (resp) begin
                busy = 1'b0;
                acc  = 1'b0;
            end
            if (exp_take) begin
                busy    = 1'b1;
                own     = exp_dm;
                last_dm = exp_dm;
                if (exp_dm) begin
                    t_we = bus.dm_we; t_addr = bus.dm_addr; t_wdata = bus.dm_wdata; t_size = bus.dm_size;
                    n_dm++;
                end else begin
                    t_we = 1'b0; t_addr = bus.if_addr; t_wdata = '0; t_size = 2'b11;
                    n_if++;
                end
            end
            #1;
            if (exp_take) begin
                if (exp_dm) bus.dm_req = 1'b0; else bus.if_req = 1'b0;
            end
        end
        n_vec++; if (n_if == 0 || n_dm == 0) begin n_err++; $display("FAIL rnd_coverage got if=%0d dm=%0d exp both >0", n_if, n_dm); end
        quiet();
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        quiet();
        test_reset();
        test_lone_fetch();
        test_tie();
        test_back_to_back_ties();
        test_slow_mem();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
